// File: rtl/nibble_serial_cla_adder_if.sv
// Request/result bundle for nibble_serial_cla_adder.
// ADDER_OVERFLOW_FLAG_EN adds the signed-overflow flag ovf.
interface nibble_serial_cla_adder_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             c_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             c_out;
`ifdef ADDER_OVERFLOW_FLAG_EN
   logic             ovf;
`endif

   modport master (
      output start, a, b, sub, c_in,
      input  busy, done, sum, c_out
`ifdef ADDER_OVERFLOW_FLAG_EN
      , ovf
`endif
   );

   modport slave (
      input  start, a, b, sub, c_in,
      output busy, done, sum, c_out
`ifdef ADDER_OVERFLOW_FLAG_EN
      , ovf
`endif
   );
endinterface

// File: rtl/nibble_serial_cla_adder.sv
// Multi-cycle adder/subtractor: one 4-bit lookahead slice per clock, LSB slice first.
// Optional signed-overflow output ovf when ADDER_OVERFLOW_FLAG_EN is defined.
module nibble_serial_cla_adder #(
   parameter int unsigned WIDTH = 32
) (
   input logic                     clk,
   input logic                     rst_n,
   nibble_serial_cla_adder_if.slave bus
);
   localparam int unsigned NIBBLES = WIDTH / 4;
   localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int unsigned LSB_W   = IDX_W + 2;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           r_state, w_state_nxt;
   logic [IDX_W-1:0] r_idx, w_idx_nxt;
   logic             r_carry, w_carry_nxt;
   logic [WIDTH-1:0] r_a, w_a_nxt;
   logic [WIDTH-1:0] r_b, w_b_nxt;
   logic [WIDTH-1:0] r_sum, w_sum_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic             r_c_out, w_c_out_nxt;
`ifdef ADDER_OVERFLOW_FLAG_EN
   logic             r_ovf, w_ovf_nxt;
`endif

   logic [LSB_W-1:0] w_lsb;
   logic [3:0]       w_a_s, w_b_s, w_p, w_g;
   logic [4:0]       w_c;
   logic             w_last;

   // Current slice and its lookahead carries; c0 comes from the carry register.
   assign w_lsb  = {r_idx, 2'b00};
   assign w_a_s  = r_a[w_lsb +: 4];
   assign w_b_s  = r_b[w_lsb +: 4];
   assign w_p    = w_a_s ^ w_b_s;
   assign w_g    = w_a_s & w_b_s;
   assign w_c[0] = r_carry;
   assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
   assign w_c[2] = w_g[1] | (w_p[1] & w_c[1]);
   assign w_c[3] = w_g[2] | (w_p[2] & w_c[2]);
   assign w_c[4] = w_g[3] | (w_p[3] & w_c[3]);
   assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_c_out <= 1'b0;
`ifdef ADDER_OVERFLOW_FLAG_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_carry <= w_carry_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_sum   <= w_sum_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_c_out <= w_c_out_nxt;
`ifdef ADDER_OVERFLOW_FLAG_EN
         r_ovf   <= w_ovf_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_carry_nxt = r_carry;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_sum_nxt   = r_sum;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_c_out_nxt = r_c_out;
`ifdef ADDER_OVERFLOW_FLAG_EN
      w_ovf_nxt   = r_ovf;
`endif
      case (r_state)
         S_IDLE: begin
            // Subtraction is A + ~B + 1, so the operand is inverted at capture.
            if (bus.start) begin
               w_a_nxt     = bus.a;
               w_b_nxt     = bus.sub ? ~bus.b : bus.b;
               w_carry_nxt = bus.sub | bus.c_in;
               w_idx_nxt   = '0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            w_sum_nxt[w_lsb +: 4] = w_p ^ w_c[3:0];
            w_carry_nxt           = w_c[4];
            w_idx_nxt             = r_idx + IDX_W'(1);
            if (w_last) begin
               w_c_out_nxt = w_c[4];
`ifdef ADDER_OVERFLOW_FLAG_EN
               w_ovf_nxt   = w_c[4] ^ w_c[3];
`endif
               w_idx_nxt   = '0;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign bus.sum   = r_sum;
   assign bus.c_out = r_c_out;
`ifdef ADDER_OVERFLOW_FLAG_EN
   assign bus.ovf   = r_ovf;
`endif
endmodule

// File: tb/tb_nibble_serial_cla_adder.sv
// Self-checking bench for nibble_serial_cla_adder: directed table, handshake/reset sequences, random ops.
// Checks ovf too when ADDER_OVERFLOW_FLAG_EN is defined.
module tb_nibble_serial_cla_adder;
   localparam int unsigned W   = 32;
   localparam int          LAT = 8;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic        cin;
      logic [31:0] exp_sum;
      logic        exp_cout;
      logic        exp_ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   nibble_serial_cla_adder_if #(.WIDTH(W)) bus ();
   nibble_serial_cla_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int   n_vec  = 0;
   int   n_miss = 0;
   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference: plain wide arithmetic on the operands.
   function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub, input logic cin);
      logic [31:0] bb;
      bb = sub ? ~b : b;
      return {1'b0, a} + {1'b0, bb} + 33'(sub | cin);
   endfunction

`ifdef ADDER_OVERFLOW_FLAG_EN
   function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b,
                                    input logic sub, input logic cin);
      logic [31:0] bb;
      logic [32:0] r;
      bb = sub ? ~b : b;
      r  = ref_add(a, b, sub, cin);
      return (a[31] == bb[31]) && (r[31] != a[31]);
   endfunction
`endif

   // Drive a request on the current negedge; it is sampled at the next posedge.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic cin);
      bus.a     = a;
      bus.b     = b;
      bus.sub   = sub;
      bus.c_in  = cin;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic launch(input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic cin);
      @(negedge clk);
      start_op(a, b, sub, cin);
   endtask

   task automatic wait_done(output int cyc, output int busy_n);
      cyc    = 0;
      busy_n = 0;
      while (bus.done !== 1'b1 && cyc < 40) begin
         if (bus.busy === 1'b1) busy_n++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic chk_model(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic cin);
      logic [32:0] r;
      r = ref_add(a, b, sub, cin);
      chk({name, " sum"}, bus.sum, r[31:0]);
      chk({name, " c_out"}, 32'(bus.c_out), 32'(r[32]));
`ifdef ADDER_OVERFLOW_FLAG_EN
      chk({name, " ovf"}, 32'(bus.ovf), 32'(ref_ovf(a, b, sub, cin)));
`endif
   endtask

   initial begin
      int          cyc, bn;
      logic [31:0] ra, rb;
      logic        rs, rc;

      tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[1] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0};
      tbl[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      tbl[3] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0};
      tbl[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      tbl[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
      tbl[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
      tbl[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.sub   = 1'b0;
      bus.c_in  = 1'b0;
      rst_n     = 1'b0;
      #12;
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset sum", bus.sum, 32'd0);
      chk("reset c_out", 32'(bus.c_out), 32'd0);
`ifdef ADDER_OVERFLOW_FLAG_EN
      chk("reset ovf", 32'(bus.ovf), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors with latency, busy width and single-cycle done.
      for (int i = 0; i < 8; i++) begin
         launch(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin);
         wait_done(cyc, bn);
         chk($sformatf("tbl%0d latency", i), 32'(cyc), 32'(LAT));
         chk($sformatf("tbl%0d busy cycles", i), 32'(bn), 32'(LAT));
         chk($sformatf("tbl%0d busy at done", i), 32'(bus.busy), 32'd0);
         chk($sformatf("tbl%0d sum", i), bus.sum, tbl[i].exp_sum);
         chk($sformatf("tbl%0d c_out", i), 32'(bus.c_out), 32'(tbl[i].exp_cout));
`ifdef ADDER_OVERFLOW_FLAG_EN
         chk($sformatf("tbl%0d ovf", i), 32'(bus.ovf), 32'(tbl[i].exp_ovf));
`endif
         @(negedge clk);
         chk($sformatf("tbl%0d done pulse", i), 32'(bus.done), 32'd0);
         chk($sformatf("tbl%0d sum held", i), bus.sum, tbl[i].exp_sum);
      end

      // start during a run is ignored and operands are not recaptured.
      launch(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      start_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
      wait_done(cyc, bn);
      chk("ignored start latency", 32'(cyc), 32'(LAT - 3));
      chk_model("ignored start", 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0);
      @(negedge clk);
      chk("ignored start no 2nd done", 32'(bus.done | bus.busy), 32'd0);

      // Back-to-back: start held in the done cycle is accepted.
      launch(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b1);
      wait_done(cyc, bn);
      chk("b2b first latency", 32'(cyc), 32'(LAT));
      chk_model("b2b first", 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b1);
      start_op(32'h0000_1000, 32'h0000_2000, 1'b1, 1'b0);
      chk("b2b done cleared", 32'(bus.done), 32'd0);
      chk("b2b busy", 32'(bus.busy), 32'd1);
      wait_done(cyc, bn);
      chk("b2b second latency", 32'(cyc), 32'(LAT));
      chk_model("b2b second", 32'h0000_1000, 32'h0000_2000, 1'b1, 1'b0);

      // Asynchronous reset mid-operation, then a fresh operation.
      launch(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst busy", 32'(bus.busy), 32'd0);
      chk("async rst done", 32'(bus.done), 32'd0);
      chk("async rst sum", bus.sum, 32'd0);
      chk("async rst c_out", 32'(bus.c_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post rst idle", 32'(bus.busy | bus.done), 32'd0);
      launch(32'h8765_4321, 32'h1234_5678, 1'b1, 1'b0);
      wait_done(cyc, bn);
      chk("post rst latency", 32'(cyc), 32'(LAT));
      chk_model("post rst", 32'h8765_4321, 32'h1234_5678, 1'b1, 1'b0);

      // Random operations against the reference.
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         rc = 1'($urandom_range(0, 1));
         if (i % 8 == 0) ra = 32'hFFFF_FFFF;
         if (i % 8 == 1) rb = 32'h8000_0000;
         launch(ra, rb, rs, rc);
         wait_done(cyc, bn);
         chk($sformatf("rnd%0d latency", i), 32'(cyc), 32'(LAT));
         chk_model($sformatf("rnd%0d", i), ra, rb, rs, rc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
